// File: rtl/lvt_mpram.sv
// Multi-port RAM: one bank per (write port, read port) pair plus a Live Value Table
// recording the last writer of each address. Clears every location after reset.
module lvt_mpram #(
    parameter int DATA_W = 5,
    parameter int ADDR_W = 7,
    parameter int NUM_WR = 2,
    parameter int NUM_RD = 2,
    parameter int BYPASS = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    input  logic [NUM_RD-1:0]        rd_en,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_valid,
    output logic                     init_busy
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int LVT_W = (NUM_WR > 1) ? $clog2(NUM_WR) : 1;

    // Handshake: there is no backpressure. A read issued with rd_en[r] in READY is
    // answered exactly one cycle later with rd_valid[r]=1; rd_valid is a one-cycle pulse.
    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [ADDR_W:0]     clr_cnt;
    logic [ADDR_W-1:0]   clr_addr;
    logic                clr_we;
    logic                port_ok;

    logic [LVT_W-1:0]    lvt [DEPTH];
    logic [NUM_RD*NUM_WR*DATA_W-1:0] bank_rd;

    assign clr_addr  = clr_cnt[ADDR_W-1:0];
    assign clr_we    = !rst && (state_q == CLEAR);
    assign port_ok   = !rst && (state_q == READY);
    assign init_busy = (state_q == CLEAR);

    always_comb begin
        state_d = state_q;
        if (state_q == CLEAR && clr_cnt == (ADDR_W+1)'(DEPTH - 1)) begin
            state_d = READY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
            clr_cnt <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == CLEAR) begin
                clr_cnt <= clr_cnt + 1'b1;
            end
        end
    end

    // Ascending loop order makes the highest-indexed writer win on a shared address.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            lvt[clr_addr] <= '0;
        end else if (port_ok) begin
            for (int w = 0; w < NUM_WR; w++) begin
                if (wr_en[w]) begin
                    lvt[wr_addr[w*ADDR_W +: ADDR_W]] <= LVT_W'(w);
                end
            end
        end
    end

    for (genvar w = 0; w < NUM_WR; w++) begin : g_wr
        for (genvar r = 0; r < NUM_RD; r++) begin : g_bank
            logic [DATA_W-1:0] mem [DEPTH];

            always_ff @(posedge clk) begin
                if (clr_we) begin
                    mem[clr_addr] <= '0;
                end else if (port_ok && wr_en[w]) begin
                    mem[wr_addr[w*ADDR_W +: ADDR_W]] <= wr_data[w*DATA_W +: DATA_W];
                end
            end

            assign bank_rd[(r*NUM_WR + w)*DATA_W +: DATA_W] = mem[rd_addr[r*ADDR_W +: ADDR_W]];
        end
    end

    for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [LVT_W-1:0]  sel;
        logic [DATA_W-1:0] word;
        logic [DATA_W-1:0] data_q;
        logic              valid_q;

        assign addr = rd_addr[r*ADDR_W +: ADDR_W];
        assign sel  = lvt[addr];

        // Later matching write ports override earlier ones, mirroring the LVT priority.
        always_comb begin
            word = bank_rd[(r*NUM_WR + int'(sel))*DATA_W +: DATA_W];
            if (BYPASS != 0) begin
                for (int w = 0; w < NUM_WR; w++) begin
                    if (wr_en[w] && wr_addr[w*ADDR_W +: ADDR_W] == addr) begin
                        word = wr_data[w*DATA_W +: DATA_W];
                    end
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                data_q  <= '0;
                valid_q <= 1'b0;
            end else if (port_ok) begin
                valid_q <= rd_en[r];
                if (rd_en[r]) begin
                    data_q <= word;
                end
            end else begin
                valid_q <= 1'b0;
            end
        end

        assign rd_data[r*DATA_W +: DATA_W] = data_q;
        assign rd_valid[r]                 = valid_q;
    end

endmodule

// File: tb/tb_lvt_mpram.sv
// Bench for lvt_mpram: a bypassing and a non-bypassing instance share stimulus and are
// compared against an array model of the memory contents.
module tb_lvt_mpram;

    localparam int DATA_W = 5;
    localparam int ADDR_W = 7;
    localparam int NUM_WR = 2;
    localparam int NUM_RD = 2;
    localparam int DEPTH  = 1 << ADDR_W;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_WR-1:0]        wr_en;
    logic [NUM_WR*ADDR_W-1:0] wr_addr;
    logic [NUM_WR*DATA_W-1:0] wr_data;
    logic [NUM_RD-1:0]        rd_en;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data_b, rd_data_n;
    logic [NUM_RD-1:0]        rd_valid_b, rd_valid_n;
    logic                     init_busy_b, init_busy_n;

    int total = 0;
    int bad   = 0;

    logic [DATA_W-1:0] model_mem [DEPTH];
    logic [DATA_W-1:0] exp_b [NUM_RD];
    logic [DATA_W-1:0] exp_n [NUM_RD];

    always #5 clk = ~clk;

    lvt_mpram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_WR(NUM_WR), .NUM_RD(NUM_RD), .BYPASS(1)) dut_b (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_valid(rd_valid_b),
        .init_busy(init_busy_b)
    );

    lvt_mpram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_WR(NUM_WR), .NUM_RD(NUM_RD), .BYPASS(0)) dut_n (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_valid(rd_valid_n),
        .init_busy(init_busy_n)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_wr(input int w, input logic en, input int a, input int d);
        wr_en[w]                    = en;
        wr_addr[w*ADDR_W +: ADDR_W] = ADDR_W'(a);
        wr_data[w*DATA_W +: DATA_W] = DATA_W'(d);
    endtask

    task automatic set_rd(input int r, input logic en, input int a);
        rd_en[r]                    = en;
        rd_addr[r*ADDR_W +: ADDR_W] = ADDR_W'(a);
    endtask

    task automatic idle_inputs();
        wr_en = '0; wr_addr = '0; wr_data = '0;
        rd_en = '0; rd_addr = '0;
    endtask

    task automatic random_inputs(input int max_addr);
        for (int w = 0; w < NUM_WR; w++)
            set_wr(w, 1'($urandom_range(0, 1)), $urandom_range(0, max_addr), int'($urandom));
        for (int r = 0; r < NUM_RD; r++)
            set_rd(r, 1'($urandom_range(0, 1)), $urandom_range(0, max_addr));
    endtask

    // One READY cycle: predict from the model, clock, then compare both instances.
    task automatic cycle();
        logic [NUM_RD-1:0] exp_v;
        int a;
        for (int r = 0; r < NUM_RD; r++) begin
            exp_v[r] = rd_en[r];
            if (rd_en[r]) begin
                a = int'(rd_addr[r*ADDR_W +: ADDR_W]);
                exp_n[r] = model_mem[a];
                exp_b[r] = model_mem[a];
                for (int w = 0; w < NUM_WR; w++)
                    if (wr_en[w] && int'(wr_addr[w*ADDR_W +: ADDR_W]) == a)
                        exp_b[r] = wr_data[w*DATA_W +: DATA_W];
            end
        end
        for (int w = 0; w < NUM_WR; w++)
            if (wr_en[w]) model_mem[int'(wr_addr[w*ADDR_W +: ADDR_W])] = wr_data[w*DATA_W +: DATA_W];
        @(posedge clk);
        #1;
        for (int r = 0; r < NUM_RD; r++) begin
            chk($sformatf("valid_b%0d", r), 32'(rd_valid_b[r]), 32'(exp_v[r]));
            chk($sformatf("valid_n%0d", r), 32'(rd_valid_n[r]), 32'(exp_v[r]));
            chk($sformatf("data_b%0d", r), 32'(rd_data_b[r*DATA_W +: DATA_W]), 32'(exp_b[r]));
            chk($sformatf("data_n%0d", r), 32'(rd_data_n[r*DATA_W +: DATA_W]), 32'(exp_n[r]));
        end
    endtask

    task automatic do_reset(input int hold);
        rst = 1'b1;
        idle_inputs();
        repeat (hold) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        for (int r = 0; r < NUM_RD; r++) begin
            exp_b[r] = '0;
            exp_n[r] = '0;
        end
        chk("reset_busy", 32'({init_busy_b, init_busy_n}), 32'h3);
        chk("reset_outs", 32'({rd_valid_b, rd_valid_n, rd_data_b, rd_data_n}), 32'h0);
    endtask

    // Drives random traffic during the clear; outputs must stay quiet throughout.
    task automatic run_clear(input int max_cycles, output int n);
        n = 0;
        while (init_busy_b && n < max_cycles) begin
            n++;
            random_inputs(DEPTH - 1);
            @(posedge clk);
            #1;
            chk("clear_quiet", 32'({rd_valid_b, rd_valid_n, rd_data_b, rd_data_n}), 32'h0);
        end
        idle_inputs();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        idle_inputs();

        // Reset and clear length
        do_reset(2);
        run_clear(400, n);
        chk("busy_len", 32'(n), 32'(DEPTH));
        chk("busy_low", 32'({init_busy_b, init_busy_n}), 32'h0);

        set_rd(0, 1, 0); set_rd(1, 1, 64);
        cycle();
        set_rd(0, 1, 127); set_rd(1, 0, 0);
        cycle();
        idle_inputs();

        // Basic writes and one-cycle valid pulse
        set_wr(0, 1, 3, 'h15); set_wr(1, 1, 9, 'h0A);
        cycle();
        idle_inputs();
        set_rd(0, 1, 3); set_rd(1, 1, 9);
        cycle();
        chk("basic_rd0", 32'(rd_data_b[0 +: DATA_W]), 32'h15);
        chk("basic_rd1", 32'(rd_data_n[DATA_W +: DATA_W]), 32'h0A);
        idle_inputs();
        cycle();

        // Same-address conflict
        set_wr(0, 1, 20, 'h01); set_wr(1, 1, 20, 'h1F);
        cycle();
        idle_inputs();
        set_rd(0, 1, 20); set_rd(1, 1, 20);
        cycle();
        chk("conflict", 32'({rd_data_b, rd_data_n}), 32'({4{5'h1F}}));
        idle_inputs();

        // Overwrite ordering across cycles
        set_wr(1, 1, 5, 'h07);
        cycle();
        idle_inputs();
        set_wr(0, 1, 5, 'h11);
        cycle();
        idle_inputs();
        set_rd(0, 1, 5);
        cycle();
        chk("overwrite", 32'(rd_data_n[0 +: DATA_W]), 32'h11);
        idle_inputs();

        // Read during write
        set_wr(0, 1, 40, 'h02);
        cycle();
        idle_inputs();
        set_wr(1, 1, 40, 'h1C); set_rd(0, 1, 40);
        cycle();
        chk("bypass_on", 32'(rd_data_b[0 +: DATA_W]), 32'h1C);
        chk("bypass_off", 32'(rd_data_n[0 +: DATA_W]), 32'h02);
        idle_inputs();
        set_rd(0, 1, 40);
        cycle();
        idle_inputs();

        // Random traffic on a narrow address window to provoke collisions
        for (int i = 0; i < 300; i++) begin
            random_inputs(15);
            cycle();
        end
        idle_inputs();

        // Reset mid-clear, writes during clear must not land
        do_reset(1);
        run_clear(50, n);
        chk("partial_clear", 32'(n), 32'd50);
        do_reset(1);
        run_clear(400, n);
        chk("busy_len_restart", 32'(n), 32'(DEPTH));
        for (int a = 0; a < DEPTH / 2; a++) begin
            set_rd(0, 1, a); set_rd(1, 1, a + DEPTH / 2);
            cycle();
        end
        idle_inputs();
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
